// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding,
// op select values and default iteration counts.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DZERO = 2'd3
  } stateT;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int DEFAULT_MULT_CYCLES = 32;
  localparam int DEFAULT_DIV_CYCLES  = 32;
  localparam int DEFAULT_CNT_W       = 6;

endpackage

// File: rtl/muldiv_cycle_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module muldiv_cycle_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             isZero
);

  logic [CNT_W-1:0] count;

  // Load wins over decrement; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative mult/div units: holds one unit's operation enable
// for a fixed number of cycles, then pulses the HI/LO write, or short-circuits
// a divide by zero into a one-cycle exception pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] operand_b,
  input  logic        abort,
  output logic        mult_op,
  output logic        div_op,
  output logic        muldiv_sel,
  output logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  // The counter runs N-1 down to 0 while the enable is held, giving N cycles.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  stateT            state;
  logic             opLatched;
  logic             acceptStart;
  logic             divZero;
  logic             cntLoad;
  logic             cntDec;
  logic             cntZero;
  logic [CNT_W-1:0] loadValue;

  assign acceptStart = (state == IDLE) && start && !abort;
  assign divZero     = (op == OP_DIV) && (operand_b == 32'd0);
  assign cntLoad     = acceptStart && !divZero;
  assign loadValue   = (op == OP_DIV) ? DIV_LOAD : MULT_LOAD;
  assign cntDec      = (state == RUN) && !abort;

  muldiv_cycle_counter #(
    .CNT_W(CNT_W)
  ) cycleCounter (
    .clk      (clk),
    .reset    (reset),
    .load     (cntLoad),
    .loadValue(loadValue),
    .dec      (cntDec),
    .isZero   (cntZero)
  );

  // Control FSM with registered outputs; abort overrides every state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      opLatched   <= OP_MULT;
      mult_op     <= 1'b0;
      div_op      <= 1'b0;
      muldiv_sel  <= 1'b0;
      hilo_write  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      hilo_write  <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        mult_op <= 1'b0;
        div_op  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              opLatched <= op;
              busy      <= 1'b1;
              if (divZero) begin
                state       <= DZERO;
                div_by_zero <= 1'b1;
              end else begin
                state      <= RUN;
                muldiv_sel <= op;
                mult_op    <= (op == OP_MULT);
                div_op     <= (op == OP_DIV);
              end
            end
          end
          RUN: begin
            if (cntZero) begin
              state      <= WRITE;
              mult_op    <= 1'b0;
              div_op     <= 1'b0;
              hilo_write <= 1'b1;
              done       <= 1'b1;
            end else begin
              mult_op <= ~opLatched;
              div_op  <= opLatched;
            end
          end
          WRITE, DZERO: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            mult_op <= 1'b0;
            div_op  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scenario bench for muldiv_sequencer: expected completion events go into a
// scoreboard at stimulus time and are matched against observed pulses.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] operand_b;
  logic        abort;
  logic        mult_op;
  logic        div_op;
  logic        muldiv_sel;
  logic        hilo_write;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int checks;
  int failures;

  typedef struct {
    logic dz;
    logic sel;
    int   k;
  } expT;

  typedef struct {
    logic dz;
    logic dn;
    logic hw;
    logic sel;
    int   k;
  } obsT;

  expT  sbq[$];
  obsT  obsq[$];
  logic multTr[0:127];
  logic divTr[0:127];
  logic busyTr[0:127];
  logic selTr[0:127];

  muldiv_sequencer #(
    .MULT_CYCLES(32),
    .DIV_CYCLES (32),
    .CNT_W      (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand_b  (operand_b),
    .abort      (abort),
    .mult_op    (mult_op),
    .div_op     (div_op),
    .muldiv_sel (muldiv_sel),
    .hilo_write (hilo_write),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Samples outputs on falling edges (sample k reflects rising edge E0+k-1),
  // records traces and pulses, and drives mid-window stimulus.
  task automatic observe(input int cycles, input int startAt, input logic startOp,
                         input logic [31:0] startB, input int abortAt, input int resetAt);
    obsT o;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      multTr[k] = mult_op;
      divTr[k]  = div_op;
      busyTr[k] = busy;
      selTr[k]  = muldiv_sel;
      if (done || hilo_write || div_by_zero) begin
        o.dz = div_by_zero; o.dn = done; o.hw = hilo_write; o.sel = muldiv_sel; o.k = k;
        obsq.push_back(o);
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b1;
      if (k == startAt) begin
        start = 1'b1; op = startOp; operand_b = startB;
      end
      if (k == abortAt) abort = 1'b1;
      if (k == resetAt) reset = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; op = 1'b0; operand_b = 32'd7; abort = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mult_op !== 1'b0) begin
      failures++;
      $display("FAIL reset_start_ignored: busy=%b mult_op=%b, required 0 0", busy, mult_op);
    end
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({mult_op, div_op, muldiv_sel, hilo_write, busy, done, div_by_zero} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, required 0000000",
               {mult_op, div_op, muldiv_sel, hilo_write, busy, done, div_by_zero});
    end
    $display("reset: outputs after release busy=%b sel=%b", busy, muldiv_sel);
  endtask

  task automatic test_mult();
    int mc, dc, bc;
    expT e;
    obsT o;
    @(negedge clk);
    start = 1'b1; op = 1'b0; operand_b = 32'd7;
    sbq.push_back('{dz: 1'b0, sel: 1'b0, k: 33});
    observe(36, -1, 1'b0, 32'd0, -1, -1);
    mc = 0; dc = 0; bc = 0;
    for (int k = 1; k <= 36; k++) begin
      mc += int'(multTr[k]); dc += int'(divTr[k]); bc += int'(busyTr[k]);
    end
    checks++;
    if (mc != 32 || multTr[32] !== 1'b1 || multTr[33] !== 1'b0) begin
      failures++; $display("FAIL mult_enable_len: got %0d cycles, required 32", mc);
    end
    checks++;
    if (dc != 0) begin failures++; $display("FAIL mult_div_op: got %0d, required 0", dc); end
    checks++;
    if (bc != 33 || busyTr[34] !== 1'b0) begin
      failures++; $display("FAIL mult_busy_len: got %0d, required 33", bc);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obsq.size() == 0) begin
        failures++; $display("FAIL mult_event: got none, required k=%0d", e.k);
      end else begin
        o = obsq.pop_front();
        if (o.k != e.k || o.dz !== e.dz || o.dn !== ~e.dz || o.hw !== ~e.dz || o.sel !== e.sel) begin
          failures++;
          $display("FAIL mult_event: got k=%0d dz=%b done=%b hw=%b sel=%b, required k=%0d dz=%b done=%b hw=%b sel=%b",
                   o.k, o.dz, o.dn, o.hw, o.sel, e.k, e.dz, ~e.dz, ~e.dz, e.sel);
        end
      end
    end
    checks++;
    if (obsq.size() != 0) begin
      failures++; $display("FAIL mult_extra_events: got %0d, required 0", obsq.size()); obsq.delete();
    end
    $display("mult: enable=%0d busy=%0d", mc, bc);
  endtask

  task automatic test_div_by_zero();
    int dc;
    expT e;
    obsT o;
    @(negedge clk);
    start = 1'b1; op = 1'b1; operand_b = 32'd0;
    sbq.push_back('{dz: 1'b1, sel: 1'b0, k: 1});
    observe(4, -1, 1'b0, 32'd0, -1, -1);
    dc = 0;
    for (int k = 1; k <= 4; k++) dc += int'(divTr[k]);
    checks++;
    if (dc != 0) begin failures++; $display("FAIL dz_div_op: got %0d cycles, required 0", dc); end
    checks++;
    if (busyTr[1] !== 1'b1 || busyTr[2] !== 1'b0) begin
      failures++; $display("FAIL dz_busy: got %b%b, required 10", busyTr[1], busyTr[2]);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obsq.size() == 0) begin
        failures++; $display("FAIL dz_event: got none, required k=%0d", e.k);
      end else begin
        o = obsq.pop_front();
        if (o.k != e.k || o.dz !== e.dz || o.dn !== ~e.dz || o.hw !== ~e.dz || o.sel !== e.sel) begin
          failures++;
          $display("FAIL dz_event: got k=%0d dz=%b done=%b hw=%b sel=%b, required k=%0d dz=%b done=0 hw=0 sel=%b",
                   o.k, o.dz, o.dn, o.hw, o.sel, e.k, e.dz, e.sel);
        end
      end
    end
    checks++;
    if (obsq.size() != 0) begin
      failures++; $display("FAIL dz_extra_events: got %0d, required 0", obsq.size()); obsq.delete();
    end
    $display("div_by_zero: div_op cycles=%0d", dc);
  endtask

  task automatic test_abort();
    int dc, mc, bc;
    @(negedge clk);
    start = 1'b1; op = 1'b1; operand_b = 32'd3;
    observe(40, 10, 1'b0, 32'd7, 20, -1);
    dc = 0; mc = 0; bc = 0;
    for (int k = 1; k <= 40; k++) begin
      dc += int'(divTr[k]); mc += int'(multTr[k]); bc += int'(busyTr[k]);
    end
    checks++;
    if (dc != 20 || divTr[21] !== 1'b0) begin
      failures++; $display("FAIL abort_div_len: got %0d cycles, required 20", dc);
    end
    checks++;
    if (mc != 0 || bc != 20) begin
      failures++; $display("FAIL abort_ignored_start: got mult=%0d busy=%0d, required 0 20", mc, bc);
    end
    checks++;
    if (selTr[40] !== 1'b1) begin
      failures++; $display("FAIL abort_sel: got %b, required 1", selTr[40]);
    end
    checks++;
    if (obsq.size() != 0) begin
      failures++; $display("FAIL abort_events: got %0d, required 0", obsq.size()); obsq.delete();
    end
    $display("abort: div_op cycles=%0d sel=%b", dc, selTr[40]);
  endtask

  task automatic test_abort_start();
    @(negedge clk);
    start = 1'b1; abort = 1'b1; op = 1'b0; operand_b = 32'd9;
    observe(3, -1, 1'b0, 32'd0, -1, -1);
    checks++;
    if (busyTr[1] !== 1'b0 || multTr[1] !== 1'b0 || selTr[3] !== 1'b1 || obsq.size() != 0) begin
      failures++;
      $display("FAIL abort_beats_start: got busy=%b mult=%b sel=%b events=%0d, required 0 0 1 0",
               busyTr[1], multTr[1], selTr[3], obsq.size());
      obsq.delete();
    end
    $display("abort_start: busy=%b sel=%b", busyTr[1], selTr[3]);
  endtask

  task automatic test_back_to_back();
    int dc, mc, bc;
    expT e;
    obsT o;
    @(negedge clk);
    start = 1'b1; op = 1'b1; operand_b = 32'd5;
    sbq.push_back('{dz: 1'b0, sel: 1'b1, k: 33});
    sbq.push_back('{dz: 1'b0, sel: 1'b0, k: 67});
    observe(70, 34, 1'b0, 32'd7, -1, -1);
    dc = 0; mc = 0; bc = 0;
    for (int k = 1; k <= 70; k++) begin
      dc += int'(divTr[k]); mc += int'(multTr[k]); bc += int'(busyTr[k]);
    end
    checks++;
    if (dc != 32 || mc != 32 || multTr[35] !== 1'b1) begin
      failures++; $display("FAIL b2b_enables: got div=%0d mult=%0d, required 32 32", dc, mc);
    end
    checks++;
    if (bc != 66 || busyTr[34] !== 1'b0) begin
      failures++; $display("FAIL b2b_busy: got %0d, required 66", bc);
    end
    checks++;
    if (selTr[34] !== 1'b1 || selTr[35] !== 1'b0) begin
      failures++; $display("FAIL b2b_sel: got %b->%b, required 1->0", selTr[34], selTr[35]);
    end
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obsq.size() == 0) begin
        failures++; $display("FAIL b2b_event: got none, required k=%0d", e.k);
      end else begin
        o = obsq.pop_front();
        if (o.k != e.k || o.dz !== e.dz || o.dn !== ~e.dz || o.hw !== ~e.dz || o.sel !== e.sel) begin
          failures++;
          $display("FAIL b2b_event: got k=%0d dz=%b done=%b hw=%b sel=%b, required k=%0d dz=%b done=1 hw=1 sel=%b",
                   o.k, o.dz, o.dn, o.hw, o.sel, e.k, e.dz, e.sel);
        end
      end
    end
    checks++;
    if (obsq.size() != 0) begin
      failures++; $display("FAIL b2b_extra_events: got %0d, required 0", obsq.size()); obsq.delete();
    end
    $display("back_to_back: div=%0d mult=%0d busy=%0d", dc, mc, bc);
  endtask

  task automatic test_reset_mid_run();
    int dc;
    @(negedge clk);
    start = 1'b1; op = 1'b1; operand_b = 32'd11;
    observe(10, -1, 1'b0, 32'd0, -1, 5);
    dc = 0;
    for (int k = 1; k <= 10; k++) dc += int'(divTr[k]);
    checks++;
    if (dc != 5 || divTr[6] !== 1'b0) begin
      failures++; $display("FAIL rst_run_div: got %0d cycles, required 5", dc);
    end
    checks++;
    if (busyTr[6] !== 1'b0 || selTr[5] !== 1'b1 || selTr[6] !== 1'b0) begin
      failures++;
      $display("FAIL rst_run_state: got busy=%b sel=%b->%b, required 0 1->0", busyTr[6], selTr[5], selTr[6]);
    end
    checks++;
    if (obsq.size() != 0) begin
      failures++; $display("FAIL rst_run_events: got %0d, required 0", obsq.size()); obsq.delete();
    end
    $display("reset_mid_run: div cycles=%0d busy=%b sel=%b", dc, busyTr[6], selTr[6]);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0; start = 1'b0; op = 1'b0; operand_b = 32'd0; abort = 1'b0;
    test_reset();
    test_mult();
    test_div_by_zero();
    test_abort();
    test_abort_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
